// File: rtl/fetch_unit_pkg.sv
// Shared core package for the fetch unit.
// Holds the default geometry of the fetch path and the queue-entry pair
// type {pc, inst} for the default configuration.
package fetch_unit_pkg;

  localparam int PC_W_DEF   = 6;   // instruction word-address width
  localparam int INST_W_DEF = 32;  // instruction width
  localparam int DEPTH_DEF  = 4;   // instruction queue entries (power of 2)

  // One instruction-queue entry: the fetch address with its returned word.
  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue for the fetch unit: a DEPTH-entry FIFO with wrapping
// read/write pointers and an explicit occupancy counter.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset (clears pointers and count)
//   flush     in   empties the queue; wins over push and pop in that cycle
//   push      in   write push_data at the tail
//   push_data in   W-bit entry
//   pop       in   drop the head entry (ignored when empty)
//   head_data out  W-bit head entry, read straight from storage
//   count     out  number of queued entries, 0..DEPTH
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int W     = PC_W_DEF + INST_W_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  // A pop against an empty queue has no effect.
  assign do_pop = pop && (count != '0);

  // Control state: pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale contents are never visible because the
  // consumer qualifies the head with count.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

  // The request throttle upstream must make a push into a full queue impossible.
  push_full_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential reads to a 1-cycle-latency
// instruction memory, queues the returned words with their addresses and
// hands them to decode over a valid/ready interface. A redirect flushes
// the queue, squashes the read in flight and restarts at redirect_pc.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   fetch_en        permits new fetch requests
//   redirect_valid  flush-and-restart pulse, redirect_pc is its target
//   imem_req        instruction memory read strobe
//   imem_addr       read address (the fetch_pc register)
//   imem_rdata      read data, valid one cycle after imem_req
//   inst_valid      queue head holds an instruction
//   inst_ready      decode accepts the head
//   inst_data       head instruction
//   inst_pc         address of the head instruction
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc
);

  localparam int              CNT_W   = $clog2(DEPTH) + 1;
  localparam int              ENTRY_W = PC_W + INST_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PC_W-1:0]    fetch_pc;
  logic               vld_p1;
  logic [PC_W-1:0]    tag_pc_p1;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   occupancy;
  logic               pop;
  logic [ENTRY_W-1:0] head_data;

  // ---- p0: request issue ----
  // Reserve a queue slot for the read in flight so a request never
  // targets a slot that its predecessor will fill.
  assign occupancy = count + CNT_W'(vld_p1);
  assign imem_req  = fetch_en && !redirect_valid && !rst && (occupancy < DEPTH_C);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= '0;
      vld_p1   <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      vld_p1   <= 1'b0;
    end else begin
      if (imem_req) fetch_pc <= fetch_pc + 1'b1;
      vld_p1 <= imem_req;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) tag_pc_p1 <= fetch_pc;
  end

  // ---- p1: read data returns and is pushed with its tag ----
  // A read in flight during redirect or reset is dropped by the queue,
  // where flush and rst win over push.
  assign pop = inst_valid && inst_ready;

  fetch_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (vld_p1),
    .push_data ({tag_pc_p1, imem_rdata}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  // ---- p2: queue head to decode ----
  // Outputs are forced to zero when empty so reset and flush leave clean values.
  assign inst_valid = (count != '0);
  assign inst_pc    = inst_valid ? head_data[ENTRY_W-1 -: PC_W] : '0;
  assign inst_data  = inst_valid ? head_data[INST_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle instruction memory model
// returning A000_0000 + address.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [5:0]  inst_pc;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_deliv;
  int          n_req;
  logic [5:0]  exp_pc;
  fetch_entry_t exp_entry;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  // Instruction memory: data only in the cycle after a request.
  always @(posedge clk)
    imem_rdata <= imem_req ? (32'hA000_0000 + {26'd0, imem_addr}) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check any accepted instruction against the expected
  // contiguous stream, then advance to just after the next rising edge.
  task automatic cyc();
    #1;
    if (inst_valid && inst_ready) begin
      exp_entry.pc   = exp_pc;
      exp_entry.inst = 32'hA000_0000 + {26'd0, exp_pc};
      chk("deliver_pc", inst_pc, exp_entry.pc);
      chk("deliver_data", inst_data, exp_entry.inst);
      exp_pc = exp_pc + 6'd1;
      n_deliv++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = 6'd0;
    n_deliv = 0;
  endtask

  initial begin
    rst = 1'b1;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 6'd0;
    exp_pc = 6'd0;
    n_deliv = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 6'd0);
    chk("rst_addr", imem_addr, 6'd0);
    chk("rst_count", dut.u_fifo.count, 3'd0);

    // Streaming from reset: first request to 0, first instruction at cycle 2
    rst = 1'b0;
    #1;
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 6'd0);
    cyc();
    chk("cyc1_empty", inst_valid, 1'b0);
    cyc();
    repeat (8) begin
      chk("stream_no_gap", inst_valid, 1'b1);
      cyc();
    end
    chk("stream_count", n_deliv, 8);

    // Decode stalled for 10 cycles: queue fills to exactly DEPTH
    inst_ready = 1'b0;
    do_reset();
    n_req = 0;
    repeat (10) begin
      #1;
      if (imem_req) n_req++;
      cyc();
    end
    chk("stall_reqs", n_req, 4);
    chk("stall_req_off", imem_req, 1'b0);
    chk("stall_full", dut.u_fifo.count, 3'd4);
    inst_ready = 1'b1;
    repeat (8) cyc();
    chk("stall_drain", n_deliv >= 5, 1'b1);

    // Redirect with 3 queued entries and a read in flight
    inst_ready = 1'b0;
    do_reset();
    repeat (4) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 6'h20;
    #1;
    chk("redir_queued", dut.u_fifo.count, 3'd3);
    chk("redir_inflight", dut.vld_p1, 1'b1);
    chk("redir_req_off", imem_req, 1'b0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    exp_pc = 6'h20;
    n_deliv = 0;
    #1;
    chk("redir_flushed", inst_valid, 1'b0);
    chk("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 6'h20);
    repeat (6) cyc();
    chk("redir_delivered", n_deliv, 4);

    // Address wrap: 3E, 3F, 00, 01
    redirect_valid = 1'b1;
    redirect_pc = 6'h3E;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    exp_pc = 6'h3E;
    n_deliv = 0;
    repeat (6) cyc();
    chk("wrap_delivered", n_deliv, 4);
    chk("wrap_next_pc", exp_pc, 6'h02);

    // Reset mid-stream with a read in flight
    rst = 1'b1;
    #1;
    chk("midrst_inflight", dut.vld_p1, 1'b1);
    @(posedge clk); #1;
    chk("midrst_valid", inst_valid, 1'b0);
    chk("midrst_req", imem_req, 1'b0);
    chk("midrst_data", inst_data, 32'd0);
    chk("midrst_pc", inst_pc, 6'd0);
    chk("midrst_addr", imem_addr, 6'd0);
    rst = 1'b0;
    exp_pc = 6'd0;
    n_deliv = 0;
    repeat (4) cyc();
    chk("midrst_restart", n_deliv, 2);

    // Random fetch_en / inst_ready for 1000 cycles
    do_reset();
    repeat (1000) begin
      fetch_en   = 1'($urandom_range(0, 1));
      inst_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("rand_progress", n_deliv > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
